mul_scheduler: RTL
==================

# mul_scheduler

Shares one 32x32 signed multiplier datapath among `NREQ` requesters. Requests are granted round-robin and carried through a `LAT`-stage pipeline. Results return on a single response channel, tagged with the requester index. The block sits between the ALU-side requesters and the multiplier; it owns arbitration, pipelining, backpressure and operation accounting.

## Interface
- `NREQ`, 2, number of requesters (1..8)
- `LAT`, 2, cycles from request acceptance to `rsp_valid` with no stall (2..4)
- `IDW`, derived: `$clog2(NREQ)` if `NREQ`>1, else 1
- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  NREQ  per-requester request valid
- `req_ready`  out  NREQ  per-requester accept; at most one bit high
- `req_a`  in  NREQ*32  multiplicands; requester i at [32*i+31:32*i], two's complement
- `req_b`  in  NREQ*32  multipliers; same packing
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response accept
- `rsp_id`  out  IDW  index of the requester that owns the response
- `rsp_data`  out  32  low 32 bits of the signed 64-bit product
- `busy`  out  1  any pipeline stage or the output register holds an op
- `op_count`  out  32  number of accepted requests; wraps modulo 2^32

## Operation
- **Arithmetic**
  - `rsp_data` = low 32 bits of sign-extended `a`*`b`; overflow wraps silently.
  - Result is identical for signed and unsigned interpretation of the low word.
- **Arbitration**
  - Pointer `ptr` resets to 0.
  - Grant goes to the first `i` with `req_valid[i]`=1, scanning `ptr`, `ptr`+1, ... modulo NREQ.
  - On acceptance, `ptr` <= (granted+1) mod NREQ.
  - With no acceptance, `ptr` holds.
  - NREQ=1: `ptr` is constant 0.
- **Handshake**
  - `req_ready[i]` = grant[i] & !stall.
  - Transfer occurs when `req_valid[i]` & `req_ready[i]`.
  - `req_ready` depends combinationally on `req_valid`.
  - Requesters hold `a`/`b` stable while valid and not ready.
- **Pipeline**
  - LAT stages, each holding {valid, id, a, b or product}.
  - The multiply is performed between stage 0 and stage 1.
  - The last stage is the output register driving `rsp_*`.
- **Stall**
  - stall = `rsp_valid` & !`rsp_ready`.
  - During stall, every stage holds and nothing is accepted.
  - Bubbles are not compressed.
- **Counters and status**
  - `op_count` increments by 1 on each accepted request.
  - `busy` = OR of all stage valid bits.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `busy`=0, `op_count`=0, `ptr`=0, all stage valids 0.
- Latency: request accepted at edge T gives `rsp_valid`=1 after edge T+LAT-1, i.e. visible in cycle T+LAT, when there is no stall.
- Throughput: 1 op/cycle. A response accepted in the same cycle as a new request lets both proceed.
- `rsp_ready`=0 with `rsp_valid`=1: `rsp_data`/`rsp_id` stay stable until accepted, for any number of cycles.
- `rsp_ready`=1 with `rsp_valid`=0: no effect.
- All requesters valid: grants rotate 0,1,...,NREQ-1,0,...; no requester waits more than NREQ-1 acceptances.
- Reset asserted mid-operation: all in-flight ops are discarded with no response, outputs go to reset values immediately, and `op_count` is cleared.
- `op_count` wraps 0xFFFFFFFF -> 0.

## Structure
- Shared package `mul_pkg`:
  - `XLEN`=32
  - typedef `mul_stage_t` {valid, id, a, b/product}
  - function `mul_lo32(a,b)` returning the low word of the signed product
- Sub-module `rr_arbiter` (parameter N):
  - inputs `req`[N], `advance`
  - outputs one-hot `grant`[N], `grant_idx`
  - internal pointer register
- The top level holds the pipeline registers, stall logic and counter.

## Test plan
- Single op, requester 0: a=0xFFFFFFF9 (-7), b=6 -> after LAT cycles `rsp_valid`=1, `rsp_id`=0, `rsp_data`=0xFFFFFFD6; `op_count`=1.
- Edge values:
  - 0x80000000*0xFFFFFFFF -> 0x80000000
  - 0x00010000*0x00010000 -> 0x00000000
  - 0x7FFFFFFF*2 -> 0xFFFFFFFE
- Both requesters valid continuously for 6 accepts -> grant order 0,1,0,1,0,1; responses in that order, one per cycle, with `rsp_ready`=1.
- Pipeline full, then `rsp_ready`=0 for 5 cycles:
  - `req_ready`=0 throughout
  - `rsp_data` stable
  - no op lost or duplicated after release
  - `op_count` equals the accepted count
- Reset asserted with 2 ops in flight -> outputs return to reset values the same cycle; no response after reset deasserts; `ptr`=0 (first grant goes to requester 0).

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and helpers for the multiplier scheduler: stage record and
// the low-word signed product used between pipeline stage 0 and 1.
package mul_pkg;

  localparam int XLEN = 32;
  localparam int ID_W = 3;  // wide enough for up to 8 requesters

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;   // operand b in stage 0, product from stage 1 on
  } mul_stage_t;

  function automatic logic [XLEN-1:0] mul_lo32(input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic signed [2*XLEN-1:0] ae, be, p;
    ae = {{XLEN{a[XLEN-1]}}, a};
    be = {{XLEN{b[XLEN-1]}}, b};
    p  = ae * be;
    return p[XLEN-1:0];
  endfunction

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_scheduler_if.sv
// Request/response bundle between the ALU-side requesters and the shared
// multiplier scheduler.
interface mul_scheduler_if
  import mul_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ-1:0][XLEN-1:0] req_a;
  logic [NREQ-1:0][XLEN-1:0] req_b;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [IDW-1:0]            rsp_id;
  logic [XLEN-1:0]           rsp_data;
  logic                      busy;
  logic [31:0]               op_count;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, busy, op_count
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, busy, op_count
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans from the pointer upward and moves the pointer
// past the winner only when the grant is actually taken.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] jj;
  logic          found;
  int            j, nx;

  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    jj        = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N) j = j - N;
      jj = j[IW-1:0];
      if (!found && req[jj]) begin
        found     = 1'b1;
        grant_idx = jj;
      end
    end
    grant = found ? (N'(1) << grant_idx) : '0;
  end

  // With N=1 the wrap below always lands on 0, so the pointer stays constant.
  always_comb begin
    ptr_d = ptr_q;
    nx    = 0;
    if (advance) begin
      nx = int'(grant_idx) + 1;
      if (nx >= N) nx = 0;
      ptr_d = nx[IW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mul_scheduler.sv
// Shares one 32x32 signed multiplier among NREQ requesters: round-robin
// grant, LAT-stage stallable pipeline, tagged single response channel.
module mul_scheduler
  import mul_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int LAT  = 2
) (
  input logic            clk,
  input logic            rst_n,
  mul_scheduler_if.slave bus
);

  localparam int IDW = id_w(NREQ);

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            stall;
  logic            accept;
  logic            busy_w;
  logic [31:0]     op_count_q, op_count_d;
  mul_stage_t      stg_q [LAT];
  mul_stage_t      stg_d [LAT];

  // The whole pipe freezes behind a held response; bubbles stay in place.
  assign stall         = stg_q[LAT-1].valid & ~bus.rsp_ready;
  assign bus.req_ready = grant & {NREQ{~stall & rst_n}};
  assign accept        = |(bus.req_valid & bus.req_ready);

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus.req_valid),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    for (int i = 0; i < LAT; i++) stg_d[i] = stg_q[i];
    if (!stall) begin
      stg_d[0].valid = accept;
      if (accept) begin
        stg_d[0].id = ID_W'(grant_idx);
        stg_d[0].a  = bus.req_a[grant_idx];
        stg_d[0].b  = bus.req_b[grant_idx];
      end
      stg_d[1]   = stg_q[0];
      stg_d[1].b = mul_lo32(stg_q[0].a, stg_q[0].b);
      for (int i = 2; i < LAT; i++) stg_d[i] = stg_q[i-1];
    end
  end

  always_comb begin
    busy_w = 1'b0;
    for (int i = 0; i < LAT; i++) busy_w = busy_w | stg_q[i].valid;
  end

  assign op_count_d = accept ? op_count_q + 32'd1 : op_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) stg_q[i] <= '0;
      op_count_q <= '0;
    end else begin
      stg_q      <= stg_d;
      op_count_q <= op_count_d;
    end
  end

  assign bus.rsp_valid = stg_q[LAT-1].valid;
  assign bus.rsp_id    = stg_q[LAT-1].id[IDW-1:0];
  assign bus.rsp_data  = stg_q[LAT-1].b;
  assign bus.busy      = busy_w;
  assign bus.op_count  = op_count_q;

endmodule
